execute_unit: RTL and testbench
===============================

// Module: execute_unit
// PURPOSE
// Multi-cycle execute stage sitting directly downstream of the register file.
// - Consumes the ra / rt / ps read values and the decoded op.
// - Computes NAND, ADD, shift or compare.
// - Drives the register-file write port (write, rw, rw_addr, ps_write, ps) for exactly one cycle per op.
// - Shifts are bit-serial (one position per cycle), so the stage exposes a start/busy/done handshake.
// PARAMETERS
// DATA_WIDTH  16                   datapath width; equals `DATA_WIDTH
// ADDR_W      $clog2(DATA_WIDTH)   register address width; also shift-amount width
// PORTS
// clk        in   1           clock, rising edge
// n_rst      in   1           asynchronous active-low reset
// start      in   1           op request; accepted only when busy==0
// op         in   3           000 NAND, 001 ADD, 010 SHL, 011 SHR, 100 CMP; 101-111 illegal
// ra         in   DATA_WIDTH  accumulator operand (regs[0])
// rt         in   DATA_WIDTH  second operand; rt[ADDR_W-1:0] is the shift amount
// ps         in   1           current predicate register value
// pred_en    in   1           op is predicated on ps
// dst_addr   in   ADDR_W      destination register
// busy       out  1           high from the cycle after accept until after the WB cycle
// done       out  1           one-cycle pulse in the WB cycle (every accepted op)
// illegal    out  1           one-cycle pulse with done for an illegal op
// write      out  1           regfile write strobe
// rw         out  DATA_WIDTH  regfile write data
// rw_addr    out  ADDR_W      regfile write address
// ps_write   out  1           predicate write strobe
// ps_out     out  1           predicate write value
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0, including busy, done, write, rw, rw_addr, ps_write and ps_out.
// - Reset is asynchronous; asserting it mid-op aborts the op with no write.
// - Accept: at the clock edge where start && state==IDLE, capture op, ra, rt, ps, pred_en and dst_addr.
//   - Later changes on the inputs do not affect the op in flight.
//   - start while busy is ignored and not queued.
// - FSM IDLE -> SHIFT -> WB -> IDLE:
//   - IDLE -> WB for NAND, ADD, CMP, illegal, predicated-off, or a shift with amount 0.
//   - IDLE -> SHIFT for a shift with amount k>0; SHIFT holds k cycles, one bit per cycle, then -> WB.
//   - WB always -> IDLE after one cycle.
// - Latency: accept at edge N; strobes are high in the cycle after edge N+1 (N+1+k for shifts).
// - Throughput: at most one op per 2 cycles.
// - Outputs are registered.
//   - Strobes (done, illegal, write, ps_write) are high only in the WB cycle.
//   - rw, rw_addr and ps_out hold their last value otherwise.
// - Results, all modulo 2^DATA_WIDTH:
//   - NAND: rw = ~(ra & rt); write=1; ps_write=0.
//   - ADD: rw = ra + rt; write=1; ps_write=1 with ps_out = carry out.
//   - SHL / SHR: logical shift of ra by rt[ADDR_W-1:0], zero fill; write=1; ps_write=0.
//   - CMP: write=0; ps_write=1 with ps_out = (ra==rt).
//   - Illegal op: done=1, illegal=1, write=0, ps_write=0.
// - Predication: if pred_en && !ps at accept, go straight to WB with done=1, write=0, ps_write=0, illegal=0.
//   - Illegal is not reported when the op is predicated off.
// - rw_addr = captured dst_addr in WB; dst_addr 0 (ra) is a legal target.
// TESTING
// - NAND: ra=16'hF0F0, rt=16'hFF00, dst 3 -> one cycle after accept: write=1, rw=16'h0FFF, rw_addr=3, ps_write=0.
// - ADD: ra=16'hFFFF, rt=16'h0001 -> rw=16'h0000, write=1, ps_write=1, ps_out=1.
// - SHL: ra=16'h0001, rt=16'h0004 -> busy for 5 cycles, then WB with rw=16'h0010; an SHL by 0 yields rw=ra after 1 cycle.
// - Predicated skip: pred_en=1, ps=0, op=ADD -> done pulse, write=0, ps_write=0; start held high during busy causes no extra op.
// - CMP and illegal: ra=rt=16'h1234 with CMP -> ps_write=1, ps_out=1, write=0; op=3'b111 -> done=1, illegal=1, no strobes.
// - Reset mid-shift: SHR by 15, n_rst low in cycle 3 -> outputs 0 immediately, no write; after release the FSM is IDLE and accepts a new op.

Source files
------------

// File: rtl/execute_unit.sv
// Multi-cycle execute stage: NAND/ADD/CMP finish in one WB cycle, shifts step one bit per cycle.
// Drives the register-file write port with single-cycle strobes and a start/busy/done handshake.
module execute_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] ra,
  input  logic [DATA_WIDTH-1:0] rt,
  input  logic                  ps,
  input  logic                  pred_en,
  input  logic [ADDR_W-1:0]     dst_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal,
  output logic                  write,
  output logic [DATA_WIDTH-1:0] rw,
  output logic [ADDR_W-1:0]     rw_addr,
  output logic                  ps_write,
  output logic                  ps_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WB    = 2'd2
  } state_t;

  localparam logic [2:0] OP_NAND = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_CMP  = 3'b100;
  localparam logic [ADDR_W-1:0] CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t                  state_r;
  logic [2:0]              op_r;
  logic [DATA_WIDTH-1:0]   acc_r;
  logic [DATA_WIDTH-1:0]   rt_r;
  logic [ADDR_W-1:0]       dst_r;
  logic [ADDR_W-1:0]       cnt_r;
  logic                    skip_r;
  logic                    skip_s;
  logic                    is_shift_s;
  logic [DATA_WIDTH:0]     sum_s;

  // Decode of the accept decision and the carry-extended adder.
  always_comb begin
    skip_s     = pred_en & ~ps;
    is_shift_s = (op == OP_SHL) || (op == OP_SHR);
    sum_s      = {1'b0, acc_r} + {1'b0, rt_r};
  end

  // Control FSM, operand capture, bit-serial shifter and registered write-port outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r  <= IDLE;
      op_r     <= 3'b000;
      acc_r    <= '0;
      rt_r     <= '0;
      dst_r    <= '0;
      cnt_r    <= '0;
      skip_r   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      write    <= 1'b0;
      rw       <= '0;
      rw_addr  <= '0;
      ps_write <= 1'b0;
      ps_out   <= 1'b0;
    end else begin
      done     <= 1'b0;
      illegal  <= 1'b0;
      write    <= 1'b0;
      ps_write <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r   <= op;
            acc_r  <= ra;
            rt_r   <= rt;
            dst_r  <= dst_addr;
            cnt_r  <= rt[ADDR_W-1:0];
            skip_r <= skip_s;
            busy   <= 1'b1;
            // A zero shift amount needs no shift cycles: acc already holds the answer.
            if (!skip_s && is_shift_s && (rt[ADDR_W-1:0] != '0)) begin
              state_r <= SHIFT;
            end else begin
              state_r <= WB;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          if (op_r == OP_SHL) begin
            acc_r <= {acc_r[DATA_WIDTH-2:0], 1'b0};
          end else begin
            acc_r <= {1'b0, acc_r[DATA_WIDTH-1:1]};
          end
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r <= WB;
          end else begin
            state_r <= SHIFT;
          end
        end
        WB: begin
          done    <= 1'b1;
          rw_addr <= dst_r;
          busy    <= 1'b0;
          state_r <= IDLE;
          if (!skip_r) begin
            case (op_r)
              OP_NAND: begin
                write <= 1'b1;
                rw    <= ~(acc_r & rt_r);
              end
              OP_ADD: begin
                write    <= 1'b1;
                rw       <= sum_s[DATA_WIDTH-1:0];
                ps_write <= 1'b1;
                ps_out   <= sum_s[DATA_WIDTH];
              end
              OP_SHL, OP_SHR: begin
                write <= 1'b1;
                rw    <= acc_r;
              end
              OP_CMP: begin
                ps_write <= 1'b1;
                ps_out   <= (acc_r == rt_r);
              end
              default: begin
                illegal <= 1'b1;
              end
            endcase
          end else begin
            illegal <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_execute_unit.sv
// Scoreboard bench for execute_unit: directed ops push expected WB results, a monitor checks each done pulse.
module tb_execute_unit;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [15:0] ra = 16'h0000;
  logic [15:0] rt = 16'h0000;
  logic        ps = 1'b0;
  logic        pred_en = 1'b0;
  logic [3:0]  dst_addr = 4'h0;
  logic        busy, done, illegal, write, ps_write, ps_out;
  logic [15:0] rw;
  logic [3:0]  rw_addr;

  typedef struct {
    int          cyc;
    logic        ill;
    logic        wr;
    logic        psw;
    logic [15:0] rw;
    logic [3:0]  addr;
    logic        pso;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  execute_unit #(.DATA_WIDTH(16), .ADDR_W(4)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .op(op), .ra(ra), .rt(rt), .ps(ps),
    .pred_en(pred_en), .dst_addr(dst_addr), .busy(busy), .done(done), .illegal(illegal),
    .write(write), .rw(rw), .rw_addr(rw_addr), .ps_write(ps_write), .ps_out(ps_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Monitor: every done pulse must match the oldest expected entry, including its cycle.
  always @(negedge clk) begin
    if (n_rst) begin
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("latency", cyc, e.cyc);
          chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
          chk("write", {31'd0, write}, {31'd0, e.wr});
          chk("ps_write", {31'd0, ps_write}, {31'd0, e.psw});
          chk("rw_addr", {28'd0, rw_addr}, {28'd0, e.addr});
          if (e.wr) chk("rw", {16'd0, rw}, {16'd0, e.rw});
          if (e.psw) chk("ps_out", {31'd0, ps_out}, {31'd0, e.pso});
        end
      end else if (write || ps_write || illegal) begin
        chk("strobe_without_done", 32'd1, 32'd0);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic p, input logic pe, input logic [3:0] d, input int k,
                       input logic ill, input logic wr, input logic psw,
                       input logic [15:0] erw, input logic epso, input int hold, input bit expect_it);
    int guard;
    logic [31:0] rnd;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy) chk("busy_timeout", 32'd1, 32'd0);
    op = o; ra = a; rt = b; ps = p; pred_en = pe; dst_addr = d; start = 1'b1;
    @(posedge clk);
    #1;
    if (expect_it) q.push_back('{cyc + 1 + k, ill, wr, psw, erw, d, epso});
    @(negedge clk);
    rnd = $urandom;
    ra = rnd[15:0]; rt = rnd[31:16];
    rnd = $urandom;
    op = rnd[2:0]; ps = rnd[3]; pred_en = rnd[4]; dst_addr = rnd[8:5];
    start = (hold > 0);
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
    chk({tag, "_write"}, {31'd0, write}, 32'd0);
    chk({tag, "_rw"}, {16'd0, rw}, 32'd0);
    chk({tag, "_rw_addr"}, {28'd0, rw_addr}, 32'd0);
    chk({tag, "_ps_write"}, {31'd0, ps_write}, 32'd0);
    chk({tag, "_ps_out"}, {31'd0, ps_out}, 32'd0);
  endtask

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    n_rst = 1'b1;

    // op, ra, rt, ps, pred_en, dst, k, ill, wr, psw, rw, ps_out, hold, expect
    issue(3'b000, 16'hF0F0, 16'hFF00, 1'b0, 1'b0, 4'd3, 0, 1'b0, 1'b1, 1'b0, 16'h0FFF, 1'b0, 0, 1'b1);
    issue(3'b001, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'd5, 0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 0, 1'b1);
    issue(3'b001, 16'h1234, 16'h0F0F, 1'b0, 1'b0, 4'd0, 0, 1'b0, 1'b1, 1'b1, 16'h2143, 1'b0, 0, 1'b1);
    issue(3'b010, 16'h0001, 16'h0004, 1'b0, 1'b0, 4'd2, 4, 1'b0, 1'b1, 1'b0, 16'h0010, 1'b0, 0, 1'b1);
    issue(3'b010, 16'hABCD, 16'hFFF0, 1'b0, 1'b0, 4'd4, 0, 1'b0, 1'b1, 1'b0, 16'hABCD, 1'b0, 0, 1'b1);
    issue(3'b011, 16'h8000, 16'h0003, 1'b0, 1'b0, 4'd6, 3, 1'b0, 1'b1, 1'b0, 16'h1000, 1'b0, 2, 1'b1);
    issue(3'b011, 16'hFFFF, 16'h000F, 1'b0, 1'b0, 4'd8, 15, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 0, 1'b1);
    issue(3'b001, 16'h1111, 16'h2222, 1'b0, 1'b1, 4'd9, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1, 1'b1);
    issue(3'b000, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 4'd7, 0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 0, 1'b1);
    issue(3'b100, 16'h1234, 16'h1234, 1'b0, 1'b0, 4'd1, 0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 0, 1'b1);
    issue(3'b100, 16'h1234, 16'h1235, 1'b0, 1'b0, 4'd1, 0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 0, 1'b1);
    issue(3'b111, 16'h5555, 16'hAAAA, 1'b0, 1'b0, 4'd10, 0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 1'b1);
    issue(3'b101, 16'h5555, 16'hAAAA, 1'b0, 1'b1, 4'd11, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 1'b1);
    issue(3'b010, 16'h0003, 16'h0005, 1'b0, 1'b1, 4'd12, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 1'b1);

    // Drain, then abort a long shift with reset: no write may ever appear for it.
    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_before_reset", q.size(), 32'd0);
    issue(3'b011, 16'hFFFF, 16'h000F, 1'b0, 1'b0, 4'd13, 15, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 0, 1'b0);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk_all_zero("midop_reset");
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_idle", {31'd0, busy}, 32'd0);
    issue(3'b000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd1, 0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0, 0, 1'b1);

    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("queue_drained", q.size(), 32'd0);
    repeat (3) @(negedge clk);
    chk("final_busy", {31'd0, busy}, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
